controlador_entrada_saida: RTL and testbench
============================================

CONTROLADOR_ENTRADA_SAIDA -- requirements
Module: controlador_entrada_saida

Interface
REQ-001 Parameter IN_OP, 6'b011101, opcode of the input instruction.
REQ-002 Parameter OUT_OP, 6'b011110, opcode of the output instruction.
REQ-003 Parameter DEBOUNCE_CICLOS, 16'd50000, consecutive stable cycles required to accept a button level.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 opcode  input  6  opcode of the instruction currently in execution.
REQ-007 processo_atual  input  32  process index (0..10) from the relative-address stage.
REQ-008 chaves  input  16  board switches, asynchronous, read only at capture.
REQ-009 botao  input  1  confirm pushbutton, raw, asynchronous, active-high.
REQ-010 dado_saida  input  32  register value to display on OUT.
REQ-011 halt  output  1  freezes PC and register writes while high.
REQ-012 dado_entrada  output  32  value delivered to the register file on IN.
REQ-013 escreve_entrada  output  1  one-cycle write strobe for dado_entrada.
REQ-014 display_valor  output  32  last OUT value.
REQ-015 display_processo  output  4  process index of the last OUT.
REQ-016 ledespera  output  1  high while waiting for the user.

Function
REQ-017 botao SHALL pass a 2-flop synchronizer, then a debouncer updating its level only after DEBOUNCE_CICLOS consecutive equal synchronized samples; counter restarts on any mismatch.
REQ-018 A press SHALL be a 0->1 transition of the debounced level, one-cycle pulse.
REQ-019 FSM states SHALL be OCIOSO, ESPERA_SOLTAR, ESPERA_APERTAR, LIBERA.
REQ-020 OCIOSO with opcode==IN_OP: halt SHALL be high combinationally in that same cycle; next state ESPERA_SOLTAR.
REQ-021 ESPERA_SOLTAR: halt=1, ledespera=1; to ESPERA_APERTAR when debounced level is 0 (a button held from a previous IN is never accepted).
REQ-022 ESPERA_APERTAR: halt=1, ledespera=1; on press, dado_entrada SHALL load {16'b0, chaves} and escreve_entrada SHALL pulse high one cycle; next state LIBERA.
REQ-023 LIBERA: halt=0, opcode ignored for exactly one cycle; next state OCIOSO.
REQ-024 Total IN latency SHALL be (cycles to press) + 2; halt deasserts the cycle after the capture edge.
REQ-025 OCIOSO with opcode==OUT_OP: next edge SHALL load display_valor<=dado_saida, display_processo<=processo_atual[3:0]; halt stays 0; back-to-back OUTs each update.
REQ-026 Any other opcode in OCIOSO SHALL leave all registers unchanged.
REQ-027 Opcode changes during ESPERA_* states SHALL be ignored.
REQ-028 A press occurring in OCIOSO or LIBERA SHALL be discarded.

Reset
REQ-029 reset_n low SHALL force, immediately: state OCIOSO, halt=0, ledespera=0, escreve_entrada=0, dado_entrada=0, display_valor=0, display_processo=0, synchronizer/debouncer level 0, counter 0.
REQ-030 Reset during an ESPERA_* state SHALL abort the IN with no write strobe.

Structure
REQ-031 IN_OP, OUT_OP and FSM state encodings SHALL live in a shared header, also used by the relative-address stage.
REQ-032 Synchronizer plus debouncer SHALL be a sub-module debounce_botao (clock, reset_n, botao -> nivel, pulso).

Verification (DEBOUNCE_CICLOS=4)
REQ-033 opcode=IN_OP, chaves=16'hA5A5, press stable 6 cycles -> halt high from first cycle; one escreve_entrada pulse; dado_entrada=32'h0000A5A5; halt low next cycle.
REQ-034 Button held across two consecutive INs -> second IN captures only after release then new press.
REQ-035 opcode=OUT_OP, dado_saida=32'h12345678, processo_atual=3 -> display_valor=32'h12345678, display_processo=4'd3 next edge; halt never high.
REQ-036 Bouncing botao 1,0,1,0 at 2-cycle intervals during ESPERA_APERTAR -> no capture; halt remains high.
REQ-037 reset_n low during ESPERA_APERTAR -> halt=0, state OCIOSO, outputs 0, no escreve_entrada pulse.
REQ-038 Press in OCIOSO, then IN issued -> no capture until a fresh press.

Source files
------------

// File: rtl/controlador_entrada_saida_pkg.sv
// ---------------------------------------------------------------------------
// controlador_entrada_saida_pkg
//
// Shared definitions for the IN/OUT controller. The relative-address stage
// imports this package as well, so the IN/OUT opcodes and the controller
// state encoding are defined in exactly one place.
//
// Contents:
//   OPCODE_IN / OPCODE_OUT  default opcodes of the IN and OUT instructions
//   DEBOUNCE_PADRAO         default number of stable cycles for the button
//   estado_t                controller FSM state encoding
//   estende_chaves()        zero-extends the 16 switches to a 32-bit word
// ---------------------------------------------------------------------------
package controlador_entrada_saida_pkg;

    localparam logic [5:0]  OPCODE_IN       = 6'b011101;
    localparam logic [5:0]  OPCODE_OUT      = 6'b011110;
    localparam logic [15:0] DEBOUNCE_PADRAO = 16'd50000;

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        ESPERA_SOLTAR  = 2'd1,
        ESPERA_APERTAR = 2'd2,
        LIBERA         = 2'd3
    } estado_t;

    function automatic logic [31:0] estende_chaves(input logic [15:0] sw);
        return {16'b0, sw};
    endfunction

endpackage

// File: rtl/controlador_entrada_saida_debounce_botao.sv
// ---------------------------------------------------------------------------
// debounce_botao
//
// Brings the raw pushbutton into the clock domain and filters contact
// bounce. The debounced level only moves after DEBOUNCE_CICLOS consecutive
// synchronized samples that all disagree with the current level; a single
// sample agreeing with the current level restarts the count.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   botao    in   raw pushbutton, asynchronous, active-high
//   nivel    out  debounced button level
//   pulso    out  one-cycle pulse in the first cycle nivel reads 1
// ---------------------------------------------------------------------------
module debounce_botao
    import controlador_entrada_saida_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic nivel,
    output logic pulso
);

    // Index of the last sample needed before the level flips. A value of 0
    // is treated like 1 so the filter never deadlocks.
    localparam logic [15:0] LIMITE = (DEBOUNCE_CICLOS == 16'd0) ? 16'd0
                                                                : DEBOUNCE_CICLOS - 16'd1;

    logic        sinc1_q;
    logic        sinc2_q;
    logic [15:0] cont_q;
    logic [15:0] cont_d;
    logic        nivel_q;
    logic        nivel_d;
    logic        pulso_q;
    logic        pulso_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc1_q <= 1'b0;
            sinc2_q <= 1'b0;
            cont_q  <= 16'd0;
            nivel_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            sinc1_q <= botao;
            sinc2_q <= sinc1_q;
            cont_q  <= cont_d;
            nivel_q <= nivel_d;
            pulso_q <= pulso_d;
        end
    end

    always_comb begin
        cont_d  = cont_q;
        nivel_d = nivel_q;
        pulso_d = 1'b0;
        if (sinc2_q == nivel_q) begin
            cont_d = 16'd0;
        end else if (cont_q >= LIMITE) begin
            // This sample completes the run of disagreeing samples.
            cont_d  = 16'd0;
            nivel_d = sinc2_q;
            pulso_d = sinc2_q;
        end else begin
            cont_d = cont_q + 16'd1;
        end
    end

    assign nivel = nivel_q;
    assign pulso = pulso_q;

endmodule

// File: rtl/controlador_entrada_saida.sv
// ---------------------------------------------------------------------------
// controlador_entrada_saida
//
// Executes the IN and OUT instructions of the processor.
//   IN : halts the pipeline, waits for the button to be released (so a button
//        held from an earlier IN is never reused), waits for a fresh press,
//        captures the switches into dado_entrada and strobes escreve_entrada,
//        then releases the halt for one cycle in which the opcode is ignored.
//   OUT: latches dado_saida and the process index into the display
//        registers on the next edge, without halting.
//
// Write strobe: escreve_entrada is high for exactly one cycle and qualifies
// dado_entrada in that cycle; the register file must accept it (no ready).
//
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   opcode[5:0]      in   opcode of the instruction in execution
//   processo_atual   in   process index (0..10), low 4 bits are displayed
//   chaves[15:0]     in   board switches, sampled only at capture
//   botao            in   raw confirm pushbutton
//   dado_saida       in   register value to display on OUT
//   halt             out  freezes PC and register writes while high
//   dado_entrada     out  value delivered to the register file on IN
//   escreve_entrada  out  one-cycle write strobe for dado_entrada
//   display_valor    out  last OUT value
//   display_processo out  process index of the last OUT
//   ledespera        out  high while waiting for the user
//   estado_dbg       out  current FSM state (estado_t encoding)
// ---------------------------------------------------------------------------
module controlador_entrada_saida
    import controlador_entrada_saida_pkg::*;
#(
    parameter logic [5:0]  IN_OP           = OPCODE_IN,
    parameter logic [5:0]  OUT_OP          = OPCODE_OUT,
    parameter logic [15:0] DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [31:0] processo_atual,
    input  logic [15:0] chaves,
    input  logic        botao,
    input  logic [31:0] dado_saida,
    output logic        halt,
    output logic [31:0] dado_entrada,
    output logic        escreve_entrada,
    output logic [31:0] display_valor,
    output logic [3:0]  display_processo,
    output logic        ledespera,
    output logic [1:0]  estado_dbg
);

    estado_t     estado_q;
    estado_t     estado_d;
    logic [31:0] dado_entrada_q;
    logic [31:0] dado_entrada_d;
    logic        escreve_q;
    logic        escreve_d;
    logic [31:0] disp_valor_q;
    logic [31:0] disp_valor_d;
    logic [3:0]  disp_proc_q;
    logic [3:0]  disp_proc_d;
    logic        halt_c;
    logic        led_c;

    logic        botao_nivel;
    logic        botao_pulso;

    // Only the low nibble of the process index is displayed.
    logic        unused_processo;
    assign unused_processo = ^processo_atual[31:4];

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .botao   (botao),
        .nivel   (botao_nivel),
        .pulso   (botao_pulso)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q       <= OCIOSO;
            dado_entrada_q <= 32'd0;
            escreve_q      <= 1'b0;
            disp_valor_q   <= 32'd0;
            disp_proc_q    <= 4'd0;
        end else begin
            estado_q       <= estado_d;
            dado_entrada_q <= dado_entrada_d;
            escreve_q      <= escreve_d;
            disp_valor_q   <= disp_valor_d;
            disp_proc_q    <= disp_proc_d;
        end
    end

    always_comb begin
        estado_d       = estado_q;
        dado_entrada_d = dado_entrada_q;
        escreve_d      = 1'b0;
        disp_valor_d   = disp_valor_q;
        disp_proc_d    = disp_proc_q;
        halt_c         = 1'b0;
        led_c          = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (opcode == IN_OP) begin
                    // Halt must already be high in the decode cycle so the
                    // PC does not advance past the IN.
                    halt_c   = 1'b1;
                    estado_d = ESPERA_SOLTAR;
                end else if (opcode == OUT_OP) begin
                    disp_valor_d = dado_saida;
                    disp_proc_d  = processo_atual[3:0];
                end
            end

            ESPERA_SOLTAR: begin
                halt_c = 1'b1;
                led_c  = 1'b1;
                if (!botao_nivel) begin
                    estado_d = ESPERA_APERTAR;
                end
            end

            ESPERA_APERTAR: begin
                halt_c = 1'b1;
                led_c  = 1'b1;
                if (botao_pulso) begin
                    dado_entrada_d = estende_chaves(chaves);
                    escreve_d      = 1'b1;
                    estado_d       = LIBERA;
                end
            end

            LIBERA: begin
                // The IN is still on the opcode bus for this cycle; ignoring
                // it prevents the same instruction from re-triggering.
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign halt             = halt_c;
    assign ledespera        = led_c;
    assign dado_entrada     = dado_entrada_q;
    assign escreve_entrada  = escreve_q;
    assign display_valor    = disp_valor_q;
    assign display_processo = disp_proc_q;
    assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
module tb_controlador_entrada_saida;
    import controlador_entrada_saida_pkg::*;

    localparam logic [5:0] T_IN  = 6'b011101;
    localparam logic [5:0] T_OUT = 6'b011110;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [31:0] processo_atual;
    logic [15:0] chaves;
    logic        botao;
    logic [31:0] dado_saida;
    logic        halt;
    logic [31:0] dado_entrada;
    logic        escreve_entrada;
    logic [31:0] display_valor;
    logic [3:0]  display_processo;
    logic        ledespera;
    logic [1:0]  estado_dbg;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    controlador_entrada_saida #(
        .IN_OP           (T_IN),
        .OUT_OP          (T_OUT),
        .DEBOUNCE_CICLOS (16'd4)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .opcode           (opcode),
        .processo_atual   (processo_atual),
        .chaves           (chaves),
        .botao            (botao),
        .dado_saida       (dado_saida),
        .halt             (halt),
        .dado_entrada     (dado_entrada),
        .escreve_entrada  (escreve_entrada),
        .display_valor    (display_valor),
        .display_processo (display_processo),
        .ledespera        (ledespera),
        .estado_dbg       (estado_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          wr_seen  = 0;
    logic [31:0] exp_q[$];       // expected dado_entrada per accepted IN
    logic [35:0] disp_q[$];      // expected {display_valor, display_processo}
    int          disp_due_q[$];  // cycle at which each display value is due
    logic [31:0] last_valor = 32'd0;
    logic [3:0]  last_proc  = 4'd0;
    logic [31:0] mon_exp;
    logic [35:0] mon_disp;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, expv, cycle);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            if (escreve_entrada) begin
                wr_seen++;
                check("halt_low_on_write", {63'd0, halt}, 64'd0);
                check("led_low_on_write", {63'd0, ledespera}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got=%0h expected=none", dado_entrada);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("dado_entrada", {32'd0, dado_entrada}, {32'd0, mon_exp});
                end
            end
            if (disp_q.size() > 0 && disp_due_q[0] <= cycle) begin
                mon_disp = disp_q.pop_front();
                void'(disp_due_q.pop_front());
                check("display_valor", {32'd0, display_valor}, {32'd0, mon_disp[35:4]});
                check("display_processo", {60'd0, display_processo}, {60'd0, mon_disp[3:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] op_outro();
        logic [5:0] op;
        op = 6'($urandom_range(0, 63));
        while (op == T_IN || op == T_OUT) op = 6'($urandom_range(0, 63));
        return op;
    endfunction

    // Issue an IN for one cycle; the expected capture is the switch value.
    task automatic issue_in(input logic [15:0] sw, input bit espera_captura);
        chaves = sw;
        opcode = T_IN;
        #1;
        check("halt_same_cycle_in", {63'd0, halt}, 64'd1);
        if (espera_captura) exp_q.push_back({16'd0, sw});
        step(1);
        opcode = op_outro();
    endtask

    task automatic issue_out(input logic [31:0] v, input logic [31:0] p);
        opcode         = T_OUT;
        dado_saida     = v;
        processo_atual = p;
        disp_q.push_back({v, p[3:0]});
        disp_due_q.push_back(cycle + 1);
        last_valor = v;
        last_proc  = p[3:0];
        #1;
        check("halt_low_out", {63'd0, halt}, 64'd0);
        step(1);
    endtask

    task automatic press(input int hold);
        botao = 1'b1;
        step(hold);
        botao = 1'b0;
        step(8);
    endtask

    task automatic wait_write(input int base);
        int n = 0;
        while (wr_seen <= base && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (wr_seen <= base) begin
            failures++;
            $display("FAIL capture_timeout: writes=%0d expected>%0d", wr_seen, base);
        end
    endtask

    task automatic check_idle_regs(input string name);
        check({name, "_valor"}, {32'd0, display_valor}, {32'd0, last_valor});
        check({name, "_proc"}, {60'd0, display_processo}, {60'd0, last_proc});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        logic [15:0] sw;
        reset_n        = 1'b0;
        opcode         = 6'd0;
        processo_atual = 32'd0;
        chaves         = 16'd0;
        botao          = 1'b0;
        dado_saida     = 32'd0;
        step(2);
        check("rst_halt", {63'd0, halt}, 64'd0);
        check("rst_led", {63'd0, ledespera}, 64'd0);
        check("rst_escreve", {63'd0, escreve_entrada}, 64'd0);
        check("rst_dado_entrada", {32'd0, dado_entrada}, 64'd0);
        check("rst_display_valor", {32'd0, display_valor}, 64'd0);
        check("rst_display_proc", {60'd0, display_processo}, 64'd0);
        check("rst_estado", {62'd0, estado_dbg}, {62'd0, OCIOSO});
        reset_n = 1'b1;
        step(2);

        // Basic IN: switches A5A5, button stable 6 cycles.
        issue_in(16'hA5A5, 1'b1);
        step(1);
        check("wait_halt", {63'd0, halt}, 64'd1);
        check("wait_led", {63'd0, ledespera}, 64'd1);
        base = wr_seen;
        press(6);
        wait_write(base);
        step(2);

        // Button held across two INs: the second waits for release + press.
        issue_in(16'h1234, 1'b1);
        base = wr_seen;
        botao = 1'b1;
        step(12);
        wait_write(base);
        step(2);
        issue_in(16'hBEEF, 1'b1);
        base = wr_seen;
        step(15);
        check("held_no_capture", 64'(wr_seen - base), 64'd0);
        check("held_halt", {63'd0, halt}, 64'd1);
        botao = 1'b0;
        step(8);
        check("released_no_capture", 64'(wr_seen - base), 64'd0);
        press(6);
        wait_write(base);
        step(2);

        // OUT with known values, then back-to-back OUTs.
        issue_out(32'h12345678, 32'd3);
        for (int i = 0; i < 4; i++) issue_out($urandom, 32'($urandom_range(0, 10)));
        opcode = op_outro();
        for (int i = 0; i < 4; i++) begin
            dado_saida     = $urandom;
            processo_atual = 32'($urandom_range(0, 10));
            step(1);
            opcode = op_outro();
        end
        check_idle_regs("other_op_keeps");

        // Bounce in ESPERA_APERTAR never reaches the debounce threshold.
        issue_in(16'h0F0F, 1'b1);
        step(2);
        base = wr_seen;
        botao = 1'b1; step(2);
        botao = 1'b0; step(2);
        botao = 1'b1; step(2);
        botao = 1'b0; step(10);
        check("bounce_no_capture", 64'(wr_seen - base), 64'd0);
        check("bounce_halt", {63'd0, halt}, 64'd1);
        press(7);
        wait_write(base);
        step(2);

        // Press while idle is discarded; the IN needs a fresh press.
        press(6);
        issue_in(16'h7E57, 1'b1);
        base = wr_seen;
        step(12);
        check("idle_press_discarded", 64'(wr_seen - base), 64'd0);
        press(6);
        wait_write(base);
        step(2);

        // Reset during ESPERA_APERTAR aborts the IN.
        issue_in(16'hDEAD, 1'b0);
        step(3);
        check("pre_rst_led", {63'd0, ledespera}, 64'd1);
        base = wr_seen;
        reset_n = 1'b0;
        #1;
        last_valor = 32'd0;
        last_proc  = 4'd0;
        check("mid_rst_halt", {63'd0, halt}, 64'd0);
        check("mid_rst_led", {63'd0, ledespera}, 64'd0);
        check("mid_rst_escreve", {63'd0, escreve_entrada}, 64'd0);
        check("mid_rst_dado_entrada", {32'd0, dado_entrada}, 64'd0);
        check("mid_rst_estado", {62'd0, estado_dbg}, {62'd0, OCIOSO});
        check_idle_regs("mid_rst_display");
        step(2);
        reset_n = 1'b1;
        step(2);
        press(6);
        check("rst_abort_no_write", 64'(wr_seen - base), 64'd0);

        // Randomized mix of INs and OUTs.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                sw = 16'($urandom);
                issue_in(sw, 1'b1);
                for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                    opcode = 6'($urandom_range(0, 63));
                    step(1);
                end
                opcode = op_outro();
                base = wr_seen;
                press(int'($urandom_range(6, 9)));
                wait_write(base);
                step(2);
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    issue_out($urandom, 32'($urandom_range(0, 10)));
                opcode = op_outro();
                step(2);
                check_idle_regs("rand_out_hold");
            end
        end

        step(5);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("disp_q_drained", 64'(disp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

endmodule
